muldiv_sched: RTL and testbench
===============================

MULDIV_SCHED -- requirements
Module: muldiv_sched

Interface
REQ-001 SHALL provide a single clock and a synchronous, active-high reset: clk and rst.
REQ-002 SHALL have these ports (name, direction, width, meaning):
 - clk  in  1  rising-edge clock
 - rst  in  1  synchronous active-high reset
 - op_valid  in  1  operation request from EX stage
 - op  in  3  000 NOP, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 NOP
 - a  in  32  source operand rs (dividend / multiplicand / MTHI-MTLO data)
 - b  in  32  source operand rt (divisor / multiplier)
 - flush  in  1  pipeline flush (exception); aborts the operation in flight
 - hilo_rd  in  1  MFHI/MFLO in EX needs hi/lo this cycle
 - hi  out  32  HI register
 - lo  out  32  LO register
 - busy  out  1  high whenever state != IDLE
 - stall  out  1  busy & (op_valid | hilo_rd)
 - done  out  1  one-cycle pulse in the final busy cycle of MULT/DIV

Function
REQ-003 SHALL implement states IDLE, MUL, DIV, FIX.
REQ-004 In IDLE, op_valid & !flush with op MULT/MULTU SHALL latch operands and enter MUL.
REQ-005 In IDLE, op_valid & !flush with op DIV/DIVU SHALL latch operands and enter DIV with iteration counter 0.
REQ-006 In IDLE, op_valid & !flush with MTHI (or MTLO) SHALL write a into hi (or lo) at that edge, with no busy cycle.
REQ-007 NOP codes SHALL have no effect.
REQ-008 MUL SHALL last exactly 1 cycle: {hi,lo} = 64-bit product at its closing edge, signed for MULT and unsigned for MULTU; done=1 during MUL; next state IDLE.
REQ-009 DIV SHALL run 32 restoring-division iterations, one quotient bit per cycle, on operand magnitudes; after iteration 31 the next state SHALL be FIX.
REQ-010 FIX SHALL last 1 cycle and apply signs (DIV only): quotient negated if a[31]^b[31], remainder negated if a[31]; lo=quotient, hi=remainder at its closing edge; done=1 during FIX; next state IDLE.
REQ-011 Divide latency SHALL be 33 busy cycles from the accept edge to the hi/lo update.
REQ-012 Divide by zero SHALL yield lo=32'hFFFFFFFF and hi=a, for both DIV and DIVU.
REQ-013 Signed overflow (DIV 32'h80000000 / 32'hFFFFFFFF) SHALL yield lo=32'h80000000 and hi=0.
REQ-014 op_valid while busy SHALL NOT be accepted; stall holds the requester until IDLE, and the request is accepted in the first IDLE cycle.
REQ-015 hi/lo SHALL change only at MTHI/MTLO accept, MUL exit, FIX exit, or reset.
REQ-016 flush in any state SHALL force IDLE at the next edge with hi/lo unchanged and done=0 that cycle; flush wins over a simultaneous accept or completion.
REQ-017 Operand inputs SHALL be sampled only at accept; later changes to a/b SHALL NOT affect the result.

Reset
REQ-018 rst SHALL override flush and op_valid.
REQ-019 On rst the block SHALL set: state=IDLE, hi=0, lo=0, counter=0, and all internal operand/remainder registers to 0.
REQ-020 During reset busy, stall and done SHALL be 0, including reset asserted mid-divide.

Configuration
REQ-021 With MULDIV_DIV0_EARLY_EN defined, DIV/DIVU with b==0 at accept SHALL go directly to FIX (2-cycle total latency), producing the REQ-012 result.
REQ-022 Without MULDIV_DIV0_EARLY_EN, divide by zero SHALL take the full 33 cycles with the same result.

Verification
REQ-023 MULT a=32'hFFFFFFFE, b=3 -> after 1 busy cycle, hi=32'hFFFFFFFF, lo=32'hFFFFFFFA, done pulse 1 cycle; MULTU same operands -> hi=2, lo=32'hFFFFFFFA.
REQ-024 DIV a=-7, b=2 -> busy 33 cycles, then lo=32'hFFFFFFFD, hi=32'hFFFFFFFF; DIVU a=100, b=7 -> lo=14, hi=2.
REQ-025 DIVU a=5, b=0 -> lo=32'hFFFFFFFF, hi=5 after 33 cycles (macro off) or 2 cycles (macro on).
REQ-026 MFHI (hilo_rd=1) issued 3 cycles into a DIV -> stall=1 until FIX completes, stall=0 in the first IDLE cycle, and hi then holds the new remainder.
REQ-027 flush at divide cycle 10 with hi=lo=32'h12345678 beforehand -> IDLE next cycle, no done pulse, hi/lo unchanged; a MTLO a=9 accepted next cycle -> lo=9.

Source files
------------

// File: rtl/muldiv_sched_if.sv
// Request/result bundle between the EX stage and the multiply/divide scheduler.
interface muldiv_sched_if;
    logic        op_valid;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        hilo_rd;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        stall;
    logic        done;

    modport master (
        output op_valid, op, a, b, flush, hilo_rd,
        input  hi, lo, busy, stall, done
    );

    modport slave (
        input  op_valid, op, a, b, flush, hilo_rd,
        output hi, lo, busy, stall, done
    );
endinterface

// File: rtl/muldiv_sched.sv
// HI/LO multiply/divide unit: 1-cycle MULT/MULTU, 32-iteration restoring DIV/DIVU plus sign fix-up.
// Define MULDIV_DIV0_EARLY_EN to route divide-by-zero straight to the fix-up state.
module muldiv_sched (
    input  logic           clk,
    input  logic           rst,
    muldiv_sched_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    state_t      r_state, w_next;
    logic [4:0]  r_cnt;
    logic [31:0] r_a, r_b, r_rem, r_quo, r_hi, r_lo;
    logic        r_signed;
    logic        w_done, w_accept, w_busy;

    assign w_accept = bus.op_valid & ~bus.flush & (r_state == S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    case (bus.op)
                        OP_MULT, OP_MULTU: w_next = S_MUL;
`ifdef MULDIV_DIV0_EARLY_EN
                        OP_DIV, OP_DIVU:   w_next = (bus.b == 32'd0) ? S_FIX : S_DIV;
`else
                        OP_DIV, OP_DIVU:   w_next = S_DIV;
`endif
                        default:           w_next = S_IDLE;
                    endcase
                end
            end
            S_MUL: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            S_DIV: begin
                if (r_cnt == 5'd31) w_next = S_FIX;
            end
            S_FIX: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        // Abort beats both a new accept and a completing operation.
        if (bus.flush) begin
            w_next = S_IDLE;
            w_done = 1'b0;
        end
        if (rst) w_done = 1'b0;
    end

    assign w_busy    = ~rst & (r_state != S_IDLE);
    assign bus.busy  = w_busy;
    assign bus.stall = w_busy & (bus.op_valid | bus.hilo_rd);
    assign bus.done  = w_done;
    assign bus.hi    = r_hi;
    assign bus.lo    = r_lo;

    // Multiply: sign/zero extend to 64 bits; the low 64 bits of the product are exact either way.
    logic [63:0] w_ma, w_mb, w_prod;
    assign w_ma   = r_signed ? {{32{r_a[31]}}, r_a} : {32'd0, r_a};
    assign w_mb   = r_signed ? {{32{r_b[31]}}, r_b} : {32'd0, r_b};
    assign w_prod = w_ma * w_mb;

    // Divide step: r_quo starts as |a| and is shifted out MSB-first while quotient bits shift in.
    logic [31:0] w_bmag, w_sub, w_rem_nx;
    logic [32:0] w_rem_sh;
    logic        w_ge, w_neg_q, w_neg_r;
    assign w_bmag   = (r_signed & r_b[31]) ? (32'd0 - r_b) : r_b;
    assign w_rem_sh = {r_rem, r_quo[31]};
    assign w_ge     = w_rem_sh >= {1'b0, w_bmag};
    assign w_sub    = w_rem_sh[31:0] - w_bmag;
    assign w_rem_nx = w_ge ? w_sub : w_rem_sh[31:0];
    assign w_neg_q  = r_signed & (r_a[31] ^ r_b[31]);
    assign w_neg_r  = r_signed & r_a[31];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= 5'd0;
            r_a      <= 32'd0;
            r_b      <= 32'd0;
            r_rem    <= 32'd0;
            r_quo    <= 32'd0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_signed <= 1'b0;
        end else if (!bus.flush) begin
            case (r_state)
                S_IDLE: begin
                    if (bus.op_valid) begin
                        case (bus.op)
                            OP_MULT, OP_MULTU: begin
                                r_a      <= bus.a;
                                r_b      <= bus.b;
                                r_signed <= (bus.op == OP_MULT);
                            end
                            OP_DIV, OP_DIVU: begin
                                r_a      <= bus.a;
                                r_b      <= bus.b;
                                r_signed <= (bus.op == OP_DIV);
                                r_rem    <= 32'd0;
                                r_quo    <= ((bus.op == OP_DIV) && bus.a[31]) ? (32'd0 - bus.a) : bus.a;
                                r_cnt    <= 5'd0;
                            end
                            OP_MTHI: r_hi <= bus.a;
                            OP_MTLO: r_lo <= bus.a;
                            default: ;
                        endcase
                    end
                end
                S_MUL: {r_hi, r_lo} <= w_prod;
                S_DIV: begin
                    r_rem <= w_rem_nx;
                    r_quo <= {r_quo[30:0], w_ge};
                    r_cnt <= r_cnt + 5'd1;
                end
                S_FIX: begin
                    if (r_b == 32'd0) begin
                        r_lo <= 32'hFFFF_FFFF;
                        r_hi <= r_a;
                    end else begin
                        r_lo <= w_neg_q ? (32'd0 - r_quo) : r_quo;
                        r_hi <= w_neg_r ? (32'd0 - r_rem) : r_rem;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_sched.sv
// Directed self-checking bench for muldiv_sched; honours MULDIV_DIV0_EARLY_EN for div-by-zero latency.
module tb_muldiv_sched;
    logic clk = 1'b0;
    logic rst;
    int   n_chk = 0;
    int   n_err = 0;

    muldiv_sched_if bus ();

    muldiv_sched u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

`ifdef MULDIV_DIV0_EARLY_EN
    localparam int DIV0_CYC = 1;
`else
    localparam int DIV0_CYC = 33;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, obs, exp);
        end
    endtask

    // Issue one op, scramble operands after accept, count busy cycles and done pulses.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int cyc, output int dn);
        @(negedge clk);
        bus.op_valid = 1'b1; bus.op = op; bus.a = a; bus.b = b;
        @(negedge clk);
        bus.op_valid = 1'b0; bus.op = 3'b000; bus.a = $urandom; bus.b = $urandom;
        #1;
        cyc = 0; dn = 0;
        while (bus.busy && cyc < 200) begin
            cyc++;
            if (bus.done) dn++;
            @(negedge clk); #1;
        end
    endtask

    task automatic check_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] b, input int ecyc,
                            input logic [31:0] ehi, input logic [31:0] elo);
        int cyc, dn;
        run_op(op, a, b, cyc, dn);
        chk({tag, "_cyc"}, cyc, ecyc);
        chk({tag, "_done"}, dn, 1);
        chk({tag, "_hi"}, bus.hi, ehi);
        chk({tag, "_lo"}, bus.lo, elo);
    endtask

    task automatic mt(input logic [2:0] op, input logic [31:0] a);
        @(negedge clk);
        bus.op_valid = 1'b1; bus.op = op; bus.a = a;
        @(negedge clk);
        bus.op_valid = 1'b0; bus.op = 3'b000;
    endtask

    initial begin
        int n, st, dn;
        rst = 1'b1;
        bus.op_valid = 1'b0; bus.op = 3'b000; bus.a = 32'd0; bus.b = 32'd0;
        bus.flush = 1'b0; bus.hilo_rd = 1'b0;
        repeat (3) @(negedge clk);
        bus.op_valid = 1'b1; bus.hilo_rd = 1'b1; #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_stall", bus.stall, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_hi", bus.hi, 0);
        chk("rst_lo", bus.lo, 0);
        bus.op_valid = 1'b0; bus.hilo_rd = 1'b0;
        @(negedge clk); rst = 1'b0;

        check_op("mult",  3'b001, 32'hFFFFFFFE, 32'd3, 1, 32'hFFFFFFFF, 32'hFFFFFFFA);
        check_op("multu", 3'b010, 32'hFFFFFFFE, 32'd3, 1, 32'h00000002, 32'hFFFFFFFA);
        check_op("div_m7_2", 3'b011, 32'hFFFFFFF9, 32'd2, 33, 32'hFFFFFFFF, 32'hFFFFFFFD);
        check_op("div_7_m2", 3'b011, 32'd7, 32'hFFFFFFFE, 33, 32'h00000001, 32'hFFFFFFFD);
        check_op("divu_100_7", 3'b100, 32'd100, 32'd7, 33, 32'd2, 32'd14);
        check_op("divu_5_0", 3'b100, 32'd5, 32'd0, DIV0_CYC, 32'd5, 32'hFFFFFFFF);
        check_op("div_m5_0", 3'b011, 32'hFFFFFFFB, 32'd0, DIV0_CYC, 32'hFFFFFFFB, 32'hFFFFFFFF);
        check_op("div_ovf", 3'b011, 32'h80000000, 32'hFFFFFFFF, 33, 32'd0, 32'h80000000);

        // MFHI three cycles into a divide: stall until FIX closes.
        @(negedge clk);
        bus.op_valid = 1'b1; bus.op = 3'b100; bus.a = 32'd100; bus.b = 32'd7;
        @(negedge clk);
        bus.op_valid = 1'b0; bus.op = 3'b000;
        repeat (2) @(negedge clk);
        bus.hilo_rd = 1'b1; #1;
        st = 0; n = 0;
        while (bus.busy && n < 200) begin
            n++;
            if (bus.stall) st++;
            @(negedge clk); #1;
        end
        chk("mfhi_stall_cyc", st, 31);
        chk("mfhi_idle_stall", bus.stall, 0);
        chk("mfhi_hi", bus.hi, 32'd2);
        bus.hilo_rd = 1'b0;

        // MTHI held behind a divide is accepted in the first IDLE cycle.
        @(negedge clk);
        bus.op_valid = 1'b1; bus.op = 3'b011; bus.a = 32'd20; bus.b = 32'd6;
        @(negedge clk);
        bus.op = 3'b101; bus.a = 32'd55; #1;
        n = 0;
        while (bus.busy && n < 200) begin
            n++;
            @(negedge clk); #1;
        end
        chk("held_cyc", n, 33);
        chk("held_lo", bus.lo, 32'd3);
        chk("held_hi", bus.hi, 32'd2);
        @(negedge clk);
        bus.op_valid = 1'b0; bus.op = 3'b000;
        chk("held_mthi", bus.hi, 32'd55);

        // Flush at divide cycle 10.
        mt(3'b101, 32'h12345678);
        mt(3'b110, 32'h12345678);
        @(negedge clk);
        bus.op_valid = 1'b1; bus.op = 3'b100; bus.a = 32'd100; bus.b = 32'd7;
        @(negedge clk);
        bus.op_valid = 1'b0; bus.op = 3'b000;
        dn = 0;
        repeat (9) begin
            #1; if (bus.done) dn++;
            @(negedge clk);
        end
        bus.flush = 1'b1; #1;
        if (bus.done) dn++;
        @(negedge clk);
        bus.flush = 1'b0; #1;
        chk("flush_busy", bus.busy, 0);
        chk("flush_done", dn, 0);
        chk("flush_hi", bus.hi, 32'h12345678);
        chk("flush_lo", bus.lo, 32'h12345678);
        bus.op_valid = 1'b1; bus.op = 3'b110; bus.a = 32'd9;
        @(negedge clk);
        bus.op_valid = 1'b0; bus.op = 3'b000;
        chk("flush_mtlo", bus.lo, 32'd9);

        // Flush wins over an MTHI accept in IDLE.
        bus.op_valid = 1'b1; bus.op = 3'b101; bus.a = 32'hDEAD0000; bus.flush = 1'b1;
        @(negedge clk);
        bus.op_valid = 1'b0; bus.op = 3'b000; bus.flush = 1'b0;
        chk("flush_mthi", bus.hi, 32'h12345678);

        // NOP codes leave hi/lo alone.
        mt(3'b111, 32'hAAAA5555);
        mt(3'b000, 32'hAAAA5555);
        chk("nop_hi", bus.hi, 32'h12345678);
        chk("nop_lo", bus.lo, 32'd9);

        // Reset mid-divide.
        @(negedge clk);
        bus.op_valid = 1'b1; bus.op = 3'b011; bus.a = 32'd50; bus.b = 32'd3;
        @(negedge clk);
        bus.op_valid = 1'b0; bus.op = 3'b000;
        repeat (4) @(negedge clk);
        bus.hilo_rd = 1'b1; #1;
        chk("mid_busy_pre", bus.busy, 1);
        rst = 1'b1; #1;
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_stall", bus.stall, 0);
        @(negedge clk);
        rst = 1'b0; bus.hilo_rd = 1'b0; #1;
        chk("mid_rst_idle", bus.busy, 0);
        chk("mid_rst_hi", bus.hi, 0);
        chk("mid_rst_lo", bus.lo, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
